// File: rtl/stats_pkg.sv
// Shared types for the per-flow statistics RMW engine.
// Entry layout is {byte_cnt, pkt_cnt}, pkt_cnt in the low half.
package stats_pkg;

  localparam int PKT_LSB       = 0;
  localparam int DEF_CNT_WIDTH = 32;
  localparam int BYTE_LSB      = DEF_CNT_WIDTH;

  typedef enum logic [1:0] {
    OP_UPD   = 2'd0,
    OP_RD    = 2'd1,
    OP_RDCLR = 2'd2
  } op_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/stats_rmw_engine_if.sv
// Update and host request/response bundle of the stats engine.
// The master is the requester side, the slave is the engine.
interface stats_rmw_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
);

  logic                   upd_valid;
  logic                   upd_ready;
  logic [ADDR_WIDTH-1:0]  upd_addr;
  logic [LEN_WIDTH-1:0]   upd_len;
  logic                   host_req_valid;
  logic                   host_req_ready;
  logic [ADDR_WIDTH-1:0]  host_req_addr;
  logic                   host_req_clear;
  logic                   host_rsp_valid;
  logic [2*CNT_WIDTH-1:0] host_rsp_data;

  modport master (
    output upd_valid, upd_addr, upd_len,
    output host_req_valid, host_req_addr,
    output host_req_clear,
    input  upd_ready, host_req_ready,
    input  host_rsp_valid, host_rsp_data
  );

  modport slave (
    input  upd_valid, upd_addr, upd_len,
    input  host_req_valid, host_req_addr,
    input  host_req_clear,
    output upd_ready, host_req_ready,
    output host_rsp_valid, host_rsp_data
  );

endinterface

// File: rtl/stats_fwd_mux.sv
// Stage-1 old-value select: newest in-flight write wins,
// then the one-cycle-older write, then BRAM read data.
module stats_fwd_mux #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 64
) (
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  s2_valid,
  input  logic [ADDR_WIDTH-1:0] s2_addr,
  input  logic [DATA_WIDTH-1:0] s2_data,
  input  logic                  s3_valid,
  input  logic [ADDR_WIDTH-1:0] s3_addr,
  input  logic [DATA_WIDTH-1:0] s3_data,
  input  logic [DATA_WIDTH-1:0] bram_data,
  output logic [DATA_WIDTH-1:0] old
);

  logic s2_hit;
  logic s3_hit;

  assign s2_hit = s2_valid & (s2_addr == rd_addr);
  assign s3_hit = s3_valid & (s3_addr == rd_addr)
                & ~s2_hit;

  always_comb begin
    old = bram_data;
    unique case (1'b1)
      s2_hit:  old = s2_data;
      s3_hit:  old = s3_data;
      default: old = bram_data;
    endcase
  end

endmodule

// File: rtl/stats_rmw_engine.sv
// Per-flow {byte_cnt, pkt_cnt} read-modify-write engine over a
// dual-port BRAM: port A reads, port B writes, forwarding hides latency.
module stats_rmw_engine
  import stats_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int CNT_WIDTH     = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int COL_WIDTH     = 8,
  parameter int HOST_MAX_WAIT = 16,
  localparam int NUM_COL      = 2*CNT_WIDTH/COL_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  stats_rmw_engine_if.slave      bus,
  output logic                   init_done,
  output logic                   bram_ena_a,
  output logic [NUM_COL-1:0]     bram_we_a,
  output logic [ADDR_WIDTH-1:0]  bram_addr_a,
  output logic [2*CNT_WIDTH-1:0] bram_din_a,
  input  logic [2*CNT_WIDTH-1:0] bram_dout_a,
  output logic                   bram_ena_b,
  output logic [NUM_COL-1:0]     bram_we_b,
  output logic [ADDR_WIDTH-1:0]  bram_addr_b,
  output logic [2*CNT_WIDTH-1:0] bram_din_b
);

  localparam int DW = 2*CNT_WIDTH;
  localparam int WW = $clog2(HOST_MAX_WAIT) + 1;

  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [WW-1:0]         wait_cnt;

  logic                  s1_valid;
  op_t                   s1_op;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [LEN_WIDTH-1:0]  s1_len;

  logic                  s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [DW-1:0]         s2_new;

  logic                  s3_valid;
  logic [ADDR_WIDTH-1:0] s3_addr;
  logic [DW-1:0]         s3_new;

  logic                  run;
  logic                  force_host;
  logic                  upd_acc;
  logic                  host_acc;
  logic                  s1_wr;
  logic [DW-1:0]         old;
  logic [DW-1:0]         nxt;

  assign run        = (state == ST_RUN);
  assign force_host = (wait_cnt == WW'(HOST_MAX_WAIT-1));

  assign bus.upd_ready      = run & ~force_host;
  assign bus.host_req_ready = run
                            & (~bus.upd_valid | force_host);

  assign upd_acc  = bus.upd_valid & bus.upd_ready;
  assign host_acc = bus.host_req_valid
                  & bus.host_req_ready;

  assign bram_ena_a  = upd_acc | host_acc;
  assign bram_addr_a = upd_acc ? bus.upd_addr
                               : bus.host_req_addr;
  assign bram_we_a   = '0;
  assign bram_din_a  = '0;

  // INIT zero-fill and stage-2 writeback share port B
  assign bram_ena_b  = ~run | s2_valid;
  assign bram_we_b   = {NUM_COL{bram_ena_b}};
  assign bram_addr_b = run ? s2_addr : init_cnt;
  assign bram_din_b  = run ? s2_new : '0;

  stats_fwd_mux #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DW)
  ) u_fwd (
    .rd_addr   (s1_addr),
    .s2_valid  (s2_valid),
    .s2_addr   (s2_addr),
    .s2_data   (s2_new),
    .s3_valid  (s3_valid),
    .s3_addr   (s3_addr),
    .s3_data   (s3_new),
    .bram_data (bram_dout_a),
    .old       (old)
  );

  assign s1_wr = (s1_op != OP_RD);

  always_comb begin
    nxt = '0;
    if (s1_op == OP_UPD) begin
      nxt[BYTE_LSB-DEF_CNT_WIDTH+CNT_WIDTH +: CNT_WIDTH] =
        old[CNT_WIDTH +: CNT_WIDTH]
        + CNT_WIDTH'(s1_len);
      nxt[PKT_LSB +: CNT_WIDTH] =
        old[PKT_LSB +: CNT_WIDTH]
        + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state              <= ST_INIT;
      init_cnt           <= '0;
      init_done          <= 1'b0;
      wait_cnt           <= '0;
      s1_valid           <= 1'b0;
      s1_op              <= OP_UPD;
      s1_addr            <= '0;
      s1_len             <= '0;
      s2_valid           <= 1'b0;
      s2_addr            <= '0;
      s2_new             <= '0;
      s3_valid           <= 1'b0;
      s3_addr            <= '0;
      s3_new             <= '0;
      bus.host_rsp_valid <= 1'b0;
      bus.host_rsp_data  <= '0;
    end else begin
      unique case (state)
        ST_INIT: begin
          init_cnt <= init_cnt + 1'b1;
          if (init_cnt == '1) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: ;
      endcase

      if (host_acc)
        wait_cnt <= '0;
      else if (run & bus.host_req_valid)
        wait_cnt <= wait_cnt + 1'b1;

      s1_valid <= upd_acc | host_acc;
      s1_op    <= upd_acc ? OP_UPD :
                  bus.host_req_clear ? OP_RDCLR : OP_RD;
      s1_addr  <= bram_addr_a;
      s1_len   <= bus.upd_len;

      s2_valid <= s1_valid & s1_wr;
      s2_addr  <= s1_addr;
      s2_new   <= nxt;

      bus.host_rsp_valid <= s1_valid
                          & (s1_op != OP_UPD);
      bus.host_rsp_data  <= old;

      // port A reads collide with same-cycle port B writes
      s3_valid <= s2_valid;
      s3_addr  <= s2_addr;
      s3_new   <= s2_new;
    end
  end

endmodule
